// File: rtl/stage3_pkg.sv
// Shared definitions for the stage-3 market-data ingest: record geometry,
// little-endian field byte offsets and the decoded record type.
package stage3_pkg;

  // Record geometry: the field layout below only fits a 32-byte record.
  localparam int REC_BYTES = 32;
  localparam int REC_BITS  = REC_BYTES * 8;
  localparam int IDX_W     = $clog2(REC_BYTES);

  // Byte offsets of each little-endian field inside a record.
  localparam int OFF_TS_NS     = 0;
  localparam int OFF_UPDATE_ID = 8;
  localparam int OFF_SIDE      = 16;
  localparam int OFF_PRICE     = 17;
  localparam int OFF_QTY       = 21;
  localparam int OFF_PAD       = 25;
  localparam int PAD_BYTES     = REC_BYTES - OFF_PAD;

  // Decoded record as handed to the order-book stage.
  typedef struct packed {
    logic [63:0] ts_ns;
    logic [63:0] update_id;
    logic [7:0]  side;
    logic [31:0] price;
    logic [31:0] qty;
  } rec_t;

  // True when any padding byte carries a nonzero value.
  function automatic logic pad_nonzero(input logic [PAD_BYTES*8-1:0] pad);
    return |pad;
  endfunction

endpackage

// File: rtl/stage3_timestamp_top_ts_counter.sv
// Free-running PL cycle counter used to timestamp record bytes.
// Wraps modulo 2^TS_W; cleared by the asynchronous active-low reset.
module stage3_ts_counter #(
  parameter int TS_W = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output logic [TS_W-1:0] count_o
);

  logic [TS_W-1:0] count_q;

  // Count every cycle; natural wrap at 2^TS_W.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + TS_W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/stage3_timestamp_top.sv
// Stage-3 PL ingest: assembles 32-byte market-data records from the UART RX
// byte stream, decodes the little-endian fields and stamps each record with
// the free-running PL counter. One record pulse per 32 accepted bytes.
// Optional padding check is built only when STAGE3_PAD_CHECK_EN is defined;
// otherwise rec_pad_err is tied low.
// TS_W must be at least 32 (rec_pl_lat is taken from the low 32 bits).
module stage3_timestamp_top
  import stage3_pkg::*;
#(
  parameter int TS_W         = 64,
  parameter int IDLE_TIMEOUT = 100000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            uart_rx_valid,
  input  logic [7:0]      uart_rx_data,
  output logic            rec_valid,
  output logic [63:0]     rec_ts_ns,
  output logic [63:0]     rec_update_id,
  output logic [7:0]      rec_side,
  output logic [31:0]     rec_price,
  output logic [31:0]     rec_qty,
  output logic [TS_W-1:0] rec_pl_ts,
  output logic [31:0]     rec_pl_lat,
  output logic [31:0]     rec_count,
  output logic            rec_pad_err
);

  localparam int                IDLE_W   = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(REC_BYTES - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TIMEOUT);

  // PL timestamp source
  logic [TS_W-1:0] pl_cnt;

  stage3_ts_counter #(
    .TS_W (TS_W)
  ) u_ts_counter (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .count_o (pl_cnt)
  );

  // Assembler state
  logic [IDX_W-1:0]    idx_q, idx_d, idx_eff;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [REC_BITS-1:0] buf_q, buf_d;
  logic [TS_W-1:0]     first_q, first_d;
  logic                timeout_fire;
  logic                last_byte;

  // Decoded view of the buffer including the byte accepted this cycle
  rec_t rec_w;

  // Output registers
  logic            rec_valid_q;
  rec_t            rec_q;
  logic [TS_W-1:0] pl_ts_q;
  logic [31:0]     pl_lat_q;
  logic [31:0]     count_q;

  // Next-state for byte index, idle counter, buffer and first-byte stamp.
  // A timeout forces the index to 0 in the same cycle it fires, so a byte
  // arriving then is taken as byte 0 of a fresh record.
  always_comb begin
    timeout_fire = (idx_q != '0) && (idle_q >= IDLE_MAX);
    idx_eff      = timeout_fire ? '0 : idx_q;
    buf_d        = buf_q;
    idx_d        = idx_eff;
    idle_d       = '0;
    first_d      = first_q;
    last_byte    = 1'b0;
    if (uart_rx_valid) begin
      buf_d[{idx_eff, 3'b000} +: 8] = uart_rx_data;
      idx_d                         = idx_eff + IDX_W'(1);
      if (idx_eff == '0) begin
        first_d = pl_cnt;
      end
      last_byte = (idx_eff == LAST_IDX);
    end else if (!timeout_fire && (idx_q != '0)) begin
      idle_d = idle_q + IDLE_W'(1);
    end
  end

  // Slice the little-endian fields out of the assembled record.
  always_comb begin
    rec_w.ts_ns     = buf_d[OFF_TS_NS*8     +: 64];
    rec_w.update_id = buf_d[OFF_UPDATE_ID*8 +: 64];
    rec_w.side      = buf_d[OFF_SIDE*8      +: 8];
    rec_w.price     = buf_d[OFF_PRICE*8     +: 32];
    rec_w.qty       = buf_d[OFF_QTY*8       +: 32];
  end

  // Assembler state registers; reset discards any partial record.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      idle_q  <= '0;
      buf_q   <= '0;
      first_q <= '0;
    end else begin
      idx_q   <= idx_d;
      idle_q  <= idle_d;
      buf_q   <= buf_d;
      first_q <= first_d;
    end
  end

  // Register the decoded record the cycle after byte 31; fields hold until
  // the next record, the valid strobe lasts one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rec_valid_q <= 1'b0;
      rec_q       <= '0;
      pl_ts_q     <= '0;
      pl_lat_q    <= '0;
      count_q     <= '0;
    end else begin
      rec_valid_q <= last_byte;
      if (last_byte) begin
        rec_q    <= rec_w;
        pl_ts_q  <= first_q;
        pl_lat_q <= pl_cnt[31:0] - first_q[31:0];
        count_q  <= count_q + 32'd1;
      end
    end
  end

`ifdef STAGE3_PAD_CHECK_EN
  logic pad_err_q;

  // Flag a record whose padding bytes are not all zero; holds with the fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pad_err_q <= 1'b0;
    end else if (last_byte) begin
      pad_err_q <= pad_nonzero(buf_d[OFF_PAD*8 +: PAD_BYTES*8]);
    end
  end

  assign rec_pad_err = pad_err_q;
`else
  assign rec_pad_err = 1'b0;
`endif

  assign rec_valid     = rec_valid_q;
  assign rec_ts_ns     = rec_q.ts_ns;
  assign rec_update_id = rec_q.update_id;
  assign rec_side      = rec_q.side;
  assign rec_price     = rec_q.price;
  assign rec_qty       = rec_q.qty;
  assign rec_pl_ts     = pl_ts_q;
  assign rec_pl_lat    = pl_lat_q;
  assign rec_count     = count_q;

endmodule

// File: tb/tb_stage3_timestamp_top.sv
// Self-checking bench for stage3_timestamp_top. A queue-based reference
// model turns each accepted byte (with the cycle it was offered) into the
// expected decoded record; a capture process records every rec_valid pulse.
module tb_stage3_timestamp_top;

  localparam int TS_W    = 64;
  localparam int IDLE_TO = 16;
`ifdef STAGE3_PAD_CHECK_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            rx_valid = 1'b0;
  logic [7:0]      rx_data = 8'h00;
  logic            rec_valid;
  logic [63:0]     rec_ts_ns;
  logic [63:0]     rec_update_id;
  logic [7:0]      rec_side;
  logic [31:0]     rec_price;
  logic [31:0]     rec_qty;
  logic [TS_W-1:0] rec_pl_ts;
  logic [31:0]     rec_pl_lat;
  logic [31:0]     rec_count;
  logic            rec_pad_err;

  stage3_timestamp_top #(
    .TS_W         (TS_W),
    .IDLE_TIMEOUT (IDLE_TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .uart_rx_valid (rx_valid),
    .uart_rx_data  (rx_data),
    .rec_valid     (rec_valid),
    .rec_ts_ns     (rec_ts_ns),
    .rec_update_id (rec_update_id),
    .rec_side      (rec_side),
    .rec_price     (rec_price),
    .rec_qty       (rec_qty),
    .rec_pl_ts     (rec_pl_ts),
    .rec_pl_lat    (rec_pl_lat),
    .rec_count     (rec_count),
    .rec_pad_err   (rec_pad_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] ts_ns;
    logic [63:0] update_id;
    logic [7:0]  side;
    logic [31:0] price;
    logic [31:0] qty;
    logic [63:0] pl_ts;
    logic [31:0] lat;
    logic [31:0] cnt;
    logic        pad;
    logic [63:0] cyc;
  } recchk_t;

  recchk_t     exp_q[$];
  recchk_t     obs_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;

  // Reference model state
  logic [63:0] mcnt;
  logic [7:0]  part[$];
  logic [63:0] stamp0;
  logic [63:0] last_cyc;
  logic [31:0] mcount = 0;

  localparam logic [63:0] REF_TS  = 64'h112210F47DE98115;
  localparam logic [63:0] REF_UID = 64'h000000024CB016EA;
  localparam logic [31:0] REF_PR  = 32'h42C90000;
  localparam logic [31:0] REF_QTY = 32'h3E800000;

  // Cycle count since reset release = value the PL counter should hold.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mcnt <= 64'd0;
    else        mcnt <= mcnt + 64'd1;
  end

  // Capture every record pulse together with the cycle it appeared in.
  always @(negedge clk) begin
    if (rst_n && rec_valid)
      obs_q.push_back({rec_ts_ns, rec_update_id, rec_side, rec_price, rec_qty,
                       rec_pl_ts, rec_pl_lat, rec_count, rec_pad_err, mcnt});
  end

  // Model one accepted byte offered in the current cycle.
  task automatic model_accept(input logic [7:0] b);
    logic [63:0] now;
    recchk_t     e;
    now = mcnt;
    if (part.size() != 0 && (now - last_cyc - 64'd1) >= 64'(IDLE_TO)) part.delete();
    if (part.size() == 0) stamp0 = now;
    part.push_back(b);
    last_cyc = now;
    if (part.size() == 32) begin
      e = '0;
      for (int i = 0; i < 8; i++) begin
        e.ts_ns     = e.ts_ns     + (64'(part[i])     << (8 * i));
        e.update_id = e.update_id + (64'(part[8 + i]) << (8 * i));
      end
      e.side = part[16];
      for (int i = 0; i < 4; i++) begin
        e.price = e.price + (32'(part[17 + i]) << (8 * i));
        e.qty   = e.qty   + (32'(part[21 + i]) << (8 * i));
      end
      for (int i = 25; i < 32; i++) if (part[i] != 8'h00) e.pad = PAD_EN;
      mcount = mcount + 32'd1;
      e.pl_ts = stamp0;
      e.lat   = 32'(now - stamp0);
      e.cnt   = mcount;
      e.cyc   = now + 64'd1;
      exp_q.push_back(e);
      part.delete();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    model_accept(b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic send_record(input logic [7:0] b[32], input int gap);
    for (int i = 0; i < 32; i++) begin
      send_byte(b[i]);
      if (i < 31) idle(gap);
    end
  endtask

  task automatic make_ref(output logic [7:0] b[32]);
    logic [63:0] ts, uid;
    logic [31:0] pr, qt;
    ts = REF_TS; uid = REF_UID; pr = REF_PR; qt = REF_QTY;
    for (int i = 0; i < 8; i++) begin
      b[i]     = ts[8*i +: 8];
      b[8 + i] = uid[8*i +: 8];
    end
    b[16] = 8'h01;
    for (int i = 0; i < 4; i++) begin
      b[17 + i] = pr[8*i +: 8];
      b[21 + i] = qt[8*i +: 8];
    end
    for (int i = 25; i < 32; i++) b[i] = 8'h00;
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    rst_n    = 1'b0;
    part.delete();
    exp_q.delete();
    obs_q.delete();
    mcount = 0;
    idle(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({rec_valid, rec_pad_err} !== 2'b00) begin
      n_fail++; $display("FAIL reset_flags act=%b req=00", {rec_valid, rec_pad_err});
    end
    n_cmp++;
    if ({rec_ts_ns, rec_update_id, rec_side, rec_price, rec_qty} !== '0) begin
      n_fail++; $display("FAIL reset_fields act=%h req=0", {rec_ts_ns, rec_update_id, rec_side, rec_price, rec_qty});
    end
    n_cmp++;
    if ({rec_pl_ts, rec_pl_lat, rec_count} !== '0) begin
      n_fail++; $display("FAIL reset_stamps act=%h req=0", {rec_pl_ts, rec_pl_lat, rec_count});
    end
  endtask

  task automatic test_reference();
    logic [7:0] b[32];
    recchk_t    e, o;
    do_reset();
    make_ref(b);
    send_record(b, 0);
    idle(3);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL ref_missing act=none req=%h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL ref_record act=%h req=%h", o, e); end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL ref_extra act=%0d req=0", obs_q.size()); obs_q.delete(); end
    n_cmp++;
    if ({rec_ts_ns, rec_update_id} !== {REF_TS, REF_UID}) begin
      n_fail++; $display("FAIL ref_ids act=%h_%h req=%h_%h", rec_ts_ns, rec_update_id, REF_TS, REF_UID);
    end
    n_cmp++;
    if ({rec_side, rec_price, rec_qty} !== {8'h01, REF_PR, REF_QTY}) begin
      n_fail++; $display("FAIL ref_px act=%h_%h_%h req=01_%h_%h", rec_side, rec_price, rec_qty, REF_PR, REF_QTY);
    end
    n_cmp++;
    if ({rec_valid, rec_pl_lat, rec_count} !== {1'b0, 32'd31, 32'd1}) begin
      n_fail++; $display("FAIL ref_hold_lat_cnt act=%b/%0d/%0d req=0/31/1", rec_valid, rec_pl_lat, rec_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b[32];
    recchk_t    e, o;
    recchk_t    got[$];
    do_reset();
    make_ref(b);
    send_record(b, 0);
    send_record(b, 0);
    idle(3);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL b2b_missing act=none req=%h", e); end
      else begin
        o = obs_q.pop_front();
        got.push_back(o);
        if (o !== e) begin n_fail++; $display("FAIL b2b_record act=%h req=%h", o, e); end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL b2b_extra act=%0d req=0", obs_q.size()); obs_q.delete(); end
    n_cmp++;
    if (got.size() != 2) begin n_fail++; $display("FAIL b2b_pulses act=%0d req=2", got.size()); end
    else if ((got[1].pl_ts - got[0].pl_ts) !== 64'd32 || (got[1].cyc - got[0].cyc) !== 64'd32
             || got[1].cnt !== 32'd2) begin
      n_fail++; $display("FAIL b2b_spacing act=%0d/%0d/%0d req=32/32/2",
                         got[1].pl_ts - got[0].pl_ts, got[1].cyc - got[0].cyc, got[1].cnt);
    end
  endtask

  task automatic test_idle_timeout(input int idle_cycles);
    logic [7:0] b[32];
    recchk_t    e, o;
    do_reset();
    make_ref(b);
    for (int i = 0; i < 10; i++) send_byte(8'($urandom));
    idle(idle_cycles);
    if (idle_cycles >= IDLE_TO) send_record(b, 0);
    else for (int i = 0; i < 22; i++) send_byte(b[i]);
    idle(3);
    n_cmp++;
    if (exp_q.size() != 1) begin n_fail++; $display("FAIL idle%0d_model act=%0d req=1", idle_cycles, exp_q.size()); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL idle%0d_missing act=none req=%h", idle_cycles, e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL idle%0d_record act=%h req=%h", idle_cycles, o, e); end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL idle%0d_extra act=%0d req=0", idle_cycles, obs_q.size()); obs_q.delete(); end
    if (idle_cycles >= IDLE_TO) begin
      n_cmp++;
      if ({rec_ts_ns, rec_count} !== {REF_TS, 32'd1}) begin
        n_fail++; $display("FAIL idle_resync act=%h/%0d req=%h/1", rec_ts_ns, rec_count, REF_TS);
      end
    end
  endtask

  task automatic test_gaps();
    logic [7:0] b[32];
    recchk_t    e, o;
    do_reset();
    make_ref(b);
    send_record(b, 1);
    idle(3);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL gap_missing act=none req=%h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL gap_record act=%h req=%h", o, e); end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL gap_extra act=%0d req=0", obs_q.size()); obs_q.delete(); end
    n_cmp++;
    if ({rec_pl_lat, rec_price} !== {32'd62, REF_PR}) begin
      n_fail++; $display("FAIL gap_lat act=%0d/%h req=62/%h", rec_pl_lat, rec_price, REF_PR);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b[32];
    recchk_t    e, o;
    do_reset();
    make_ref(b);
    for (int i = 0; i < 20; i++) send_byte(8'($urandom));
    do_reset();
    send_record(b, 0);
    idle(3);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL rstmid_missing act=none req=%h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL rstmid_record act=%h req=%h", o, e); end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL rstmid_extra act=%0d req=0", obs_q.size()); obs_q.delete(); end
    n_cmp++;
    if ({rec_count, rec_update_id, rec_pl_lat} !== {32'd1, REF_UID, 32'd31}) begin
      n_fail++; $display("FAIL rstmid_fields act=%0d/%h/%0d req=1/%h/31", rec_count, rec_update_id, rec_pl_lat, REF_UID);
    end
  endtask

  task automatic test_pad();
    logic [7:0] b[32];
    recchk_t    e, o;
    do_reset();
    make_ref(b);
    b[28] = 8'hFF;
    send_record(b, 0);
    idle(3);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL pad_missing act=none req=%h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL pad_record act=%h req=%h", o, e); end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL pad_extra act=%0d req=0", obs_q.size()); obs_q.delete(); end
    n_cmp++;
    if (rec_pad_err !== PAD_EN) begin
      n_fail++; $display("FAIL pad_flag_hold act=%b req=%b", rec_pad_err, PAD_EN);
    end
  endtask

  task automatic test_random();
    logic [7:0] b[32];
    recchk_t    e, o;
    do_reset();
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 32; i++) b[i] = 8'($urandom);
      if ($urandom_range(0, 1) == 0) for (int i = 25; i < 32; i++) b[i] = 8'h00;
      send_record(b, $urandom_range(0, 2));
    end
    idle(3);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL rand_missing act=none req=%h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL rand_record act=%h req=%h", o, e); end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL rand_extra act=%0d req=0", obs_q.size()); obs_q.delete(); end
  endtask

  initial begin
    test_reset();
    test_reference();
    test_back_to_back();
    test_idle_timeout(IDLE_TO);
    test_idle_timeout(IDLE_TO - 1);
    test_gaps();
    test_reset_mid();
    test_pad();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
